// File: rtl/pe_ctrl_fsm_if.sv
// Control-side bundle between the accelerator controller and pe_ctrl_fsm.
// Optional perf_stall_cnt is present only when PE_CTRL_PERF_EN is defined.
interface pe_ctrl_fsm_if #(
  parameter int CFG_W = 32
);
  logic             stall;
  logic             start_conv;
  logic             start_again;
  logic [CFG_W-1:0] cfg_ci;
  logic [CFG_W-1:0] cfg_co;
  logic [CFG_W-1:0] cfg_rows;
  logic             ifm_read;
  logic             wgt_read;
  logic             p_valid_output;
  logic             last_chanel_output;
  logic             end_conv;
  logic             busy;
`ifdef PE_CTRL_PERF_EN
  logic [31:0]      perf_stall_cnt;

  modport master (
    output stall, start_conv, start_again,
    output cfg_ci, cfg_co, cfg_rows,
    input  ifm_read, wgt_read,
    input  p_valid_output, last_chanel_output,
    input  end_conv, busy, perf_stall_cnt
  );

  modport slave (
    input  stall, start_conv, start_again,
    input  cfg_ci, cfg_co, cfg_rows,
    output ifm_read, wgt_read,
    output p_valid_output, last_chanel_output,
    output end_conv, busy, perf_stall_cnt
  );
`else
  modport master (
    output stall, start_conv, start_again,
    output cfg_ci, cfg_co, cfg_rows,
    input  ifm_read, wgt_read,
    input  p_valid_output, last_chanel_output,
    input  end_conv, busy
  );

  modport slave (
    input  stall, start_conv, start_again,
    input  cfg_ci, cfg_co, cfg_rows,
    output ifm_read, wgt_read,
    output p_valid_output, last_chanel_output,
    output end_conv, busy
  );
`endif
endinterface

// File: rtl/pe_ctrl_fsm.sv
// PE array control FSM: preload/stream sequencing, tile walk, psum delay.
// Define PE_CTRL_PERF_EN to add the saturating perf_stall_cnt counter.
module pe_ctrl_fsm #(
  parameter int TILE_LEN   = 16,
  parameter int K_PRE      = 3,
  parameter int CH_GRP     = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int CFG_W      = 32
) (
  input logic         clk,
  input logic         rst_n,
  pe_ctrl_fsm_if.slave bus
);
  localparam int LG = $clog2(CH_GRP);
  localparam int CW = CFG_W + LG;
  localparam int MX = (K_PRE > TILE_LEN) ? K_PRE : TILE_LEN;
  localparam int PW = $clog2(MX) + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, STREAM, WAIT, FINISH
  } state_t;

  state_t  state;
  logic [PW-1:0] cyc;
  logic [CW-1:0] pass, row, co;
  logic [CW-1:0] ci_last, co_last, row_last;
  logic ifm_q, wgt_q, pv_q, lc_q;
  logic end_q, busy_q;
  logic [PIPE_DEPTH-1:0] pv_dl, lc_dl;
  logic last_pass, last_tile;

  assign last_pass = (pass == ci_last);
  assign last_tile = (row == row_last) &&
                     (co == co_last);

  // Outputs are assigned alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cyc      <= '0;
      pass     <= '0;
      row      <= '0;
      co       <= '0;
      ci_last  <= '0;
      co_last  <= '0;
      row_last <= '0;
      ifm_q    <= 1'b0;
      wgt_q    <= 1'b0;
      pv_q     <= 1'b0;
      lc_q     <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (!bus.stall) begin
      unique case (state)
        IDLE: if (bus.start_conv) begin
          ci_last  <= (CW'(bus.cfg_ci) << LG)
                    | CW'(CH_GRP - 1);
          co_last  <= (CW'(bus.cfg_co) << LG)
                    | CW'(CH_GRP - 1);
          row_last <= CW'(bus.cfg_rows);
          cyc      <= '0;
          pass     <= '0;
          row      <= '0;
          co       <= '0;
          state    <= LOAD;
          ifm_q    <= 1'b1;
          wgt_q    <= 1'b1;
          busy_q   <= 1'b1;
        end
        LOAD: if (cyc == PW'(K_PRE - 1)) begin
          cyc   <= '0;
          state <= STREAM;
          wgt_q <= 1'b0;
          pv_q  <= 1'b1;
          lc_q  <= last_pass;
        end else begin
          cyc <= cyc + 1'b1;
        end
        STREAM: if (cyc == PW'(TILE_LEN - 1)) begin
          cyc  <= '0;
          pv_q <= 1'b0;
          lc_q <= 1'b0;
          if (!last_pass) begin
            pass  <= pass + 1'b1;
            state <= LOAD;
            wgt_q <= 1'b1;
          end else if (!last_tile) begin
            pass  <= '0;
            state <= WAIT;
            ifm_q <= 1'b0;
            if (row == row_last) begin
              row <= '0;
              co  <= co + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            state <= FINISH;
            ifm_q <= 1'b0;
            end_q <= 1'b1;
          end
        end else begin
          cyc <= cyc + 1'b1;
        end
        WAIT: if (bus.start_again) begin
          state <= LOAD;
          ifm_q <= 1'b1;
          wgt_q <= 1'b1;
        end
        FINISH: begin
          state  <= IDLE;
          end_q  <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_dl <= '0;
      lc_dl <= '0;
    end else if (!bus.stall) begin
      pv_dl <= (pv_dl << 1) | PIPE_DEPTH'(pv_q);
      lc_dl <= (lc_dl << 1) | PIPE_DEPTH'(lc_q);
    end
  end

  assign bus.ifm_read           = ifm_q;
  assign bus.wgt_read           = wgt_q;
  assign bus.p_valid_output     = pv_dl[PIPE_DEPTH-1];
  assign bus.last_chanel_output = lc_dl[PIPE_DEPTH-1];
  assign bus.end_conv           = end_q;
  assign bus.busy               = busy_q;

`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf <= '0;
    end else if (bus.stall) begin
      if (busy_q && perf != 32'hFFFF_FFFF)
        perf <= perf + 1'b1;
    end else if (state == IDLE && bus.start_conv) begin
      perf <= '0;
    end
  end

  assign bus.perf_stall_cnt = perf;
`endif
endmodule
